axis_rr_packet_arbiter: RTL and testbench
=========================================

Name: axis_rr_packet_arbiter

Overview:
- Parametrised N-to-1 AXI-Stream round-robin arbiter and mux with flattened per-channel vectors, packet-locked grants and a registered output stage.
- Merges CHANNEL_NUM packet sources into one stream ahead of DMA/FIFO sinks.
- Grants never change mid-packet; fairness is per packet, not per beat.

Parameters:
- DATA_WIDTH, 32, tdata width per channel; must be a multiple of 8.
- CHANNEL_NUM, 8, number of slave channels; 2..32.
- KEEP_WIDTH (localparam), DATA_WIDTH/8, tkeep width per channel.
- SEL_WIDTH (localparam), max(1, $clog2(CHANNEL_NUM)), channel index width.

Ports:
- axis_clk  in  1  clock; all logic on the rising edge.
- axis_rst  in  1  reset; synchronous, active-high.
- s_axis_tvalid  in  CHANNEL_NUM  per-channel valid; bit i = channel i.
- s_axis_tready  out  CHANNEL_NUM  per-channel ready; at most one bit high.
- s_axis_tdata  in  CHANNEL_NUM*DATA_WIDTH  channel i at [i*DATA_WIDTH +: DATA_WIDTH].
- s_axis_tkeep  in  CHANNEL_NUM*KEEP_WIDTH  channel i at [i*KEEP_WIDTH +: KEEP_WIDTH].
- s_axis_tlast  in  CHANNEL_NUM  per-channel end of packet.
- m_axis_tvalid  out  1  registered output valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  registered data.
- m_axis_tkeep  out  KEEP_WIDTH  registered keep.
- m_axis_tlast  out  1  registered last.
- grant_o  out  CHANNEL_NUM  one-hot current grant; 0 when idle.
- busy_o  out  1  high while in state LOCKED.

Behaviour:
- Reset (axis_rst=1 at a clock edge): state=IDLE; grant_o=0; s_axis_tready=0; m_axis_tvalid/tdata/tkeep/tlast=0; last-grant pointer=CHANNEL_NUM-1, so channel 0 has first priority. Any packet in flight is abandoned without flushing; the output register is cleared.
- FSM, state IDLE:
  - If any s_axis_tvalid is high, the winner is the first requesting channel searching upward from pointer+1 with wrap-around.
  - Next edge: grant_o = onehot(winner), pointer = winner, state = LOCKED.
  - If no request, stay in IDLE.
- FSM, state LOCKED:
  - s_axis_tready[g] = !m_axis_tvalid || m_axis_tready. All other tready bits are 0.
  - Beat accepted (s_axis_tvalid[g] && s_axis_tready[g]): the beat's tdata/tkeep/tlast load into the output register and m_axis_tvalid is set next edge.
  - Output register with m_axis_tready high and no new beat accepted: m_axis_tvalid clears.
  - Beat accepted with tlast=1: next state IDLE, grant_o=0. Exactly one arbitration cycle (bubble) follows each packet.
- Latency: request in IDLE cycle 0 -> tready in cycle 1 -> m_axis_tvalid in cycle 2. Steady state gives 1 beat/clock while valid and ready are both held high.
- Output register contents are stable while m_axis_tvalid=1 and m_axis_tready=0. AXI-S rule: m_axis_tvalid never depends combinationally on m_axis_tready.
- Non-granted channels never see tready; their valid/data must be held per AXI-S.
- tlast is carried only in the output register; a granted channel's tvalid dropping mid-packet keeps the lock; no timeout.
- Single requester: that channel wins every arbitration; the pointer wraps at CHANNEL_NUM-1 -> 0.
- Request arriving in the same cycle as a tlast acceptance: it is considered in the following IDLE cycle, not the current one.

Optional Feature:
- Macro: AXIS_RR_PACKET_ARBITER_TID_EN.
- Defined: adds output m_axis_tid [SEL_WIDTH-1:0], registered alongside tdata, carrying the granted channel index of each beat. Resets to 0.
- Undefined: the port and its register are absent.
- Arbitration and timing are identical in both builds.

Test Plan:
- Reset then idle, all tvalid=0 for 10 clocks -> grant_o=0, s_axis_tready=0, m_axis_tvalid=0 throughout.
- Channel 3 only sends a 4-beat packet 0xA0..0xA3, m_axis_tready=1 -> grant_o=0x08; m_axis_tdata A0,A1,A2,A3 on consecutive cycles starting 2 clocks after the request; tlast only on A3.
- Channels 0, 2 and 7 hold 2-beat packets continuously after reset -> packet order 0,2,7,0,2,7; one idle cycle between packets; never an interleaved beat.
- Channel 1 packet, m_axis_tready toggled 1,0,0,1,... -> no beat lost or duplicated; m_axis_tdata stable during each low cycle; s_axis_tready[1]=0 while the register is full and stalled.
- axis_rst pulsed for 1 clock mid-packet on channel 5 -> next cycle m_axis_tvalid=0, grant_o=0; the next arbitration starts from channel 0.
- TID_EN build, channels 4 and 6 active -> m_axis_tid=4 on every beat of channel 4 packets and 6 on every beat of channel 6 packets.

Source files
------------

// File: rtl/axis_rr_packet_arbiter.sv
// N-to-1 AXI-Stream round-robin packet arbiter with a registered output stage.
// Optional macro AXIS_RR_PACKET_ARBITER_TID_EN adds m_axis_tid (granted channel index).
module axis_rr_packet_arbiter #(
    parameter int  DATA_WIDTH  = 32,
    parameter int  CHANNEL_NUM = 8,
    localparam int KEEP_WIDTH  = DATA_WIDTH / 8,
    localparam int SEL_WIDTH   = (CHANNEL_NUM > 1) ? $clog2(CHANNEL_NUM) : 1
) (
    input  logic                             axis_clk,
    input  logic                             axis_rst,
    input  logic [CHANNEL_NUM-1:0]           s_axis_tvalid,
    output logic [CHANNEL_NUM-1:0]           s_axis_tready,
    input  logic [CHANNEL_NUM*DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [CHANNEL_NUM*KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic [CHANNEL_NUM-1:0]           s_axis_tlast,
    output logic                             m_axis_tvalid,
    input  logic                             m_axis_tready,
    output logic [DATA_WIDTH-1:0]            m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]            m_axis_tkeep,
    output logic                             m_axis_tlast,
`ifdef AXIS_RR_PACKET_ARBITER_TID_EN
    output logic [SEL_WIDTH-1:0]             m_axis_tid,
`endif
    output logic [CHANNEL_NUM-1:0]           grant_o,
    output logic                             busy_o
);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t                 state, state_next;
    logic [SEL_WIDTH-1:0]   ptr, ptr_next, winner;
    logic [CHANNEL_NUM-1:0] grant, grant_next;
    logic                   found;
    logic                   slot_ready, accept;
    logic                   sel_valid, sel_last;
    logic [DATA_WIDTH-1:0]  sel_data;
    logic [KEEP_WIDTH-1:0]  sel_keep;

    // Two fixed-index passes: channels above the pointer first, then wrap to the rest.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (!found && s_axis_tvalid[i] && (i > int'(ptr))) begin
                found  = 1'b1;
                winner = SEL_WIDTH'(i);
            end
        end
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (!found && s_axis_tvalid[i] && (i <= int'(ptr))) begin
                found  = 1'b1;
                winner = SEL_WIDTH'(i);
            end
        end
    end

    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        for (int i = 0; i < CHANNEL_NUM; i++) begin
            if (grant[i]) begin
                sel_valid = s_axis_tvalid[i];
                sel_last  = s_axis_tlast[i];
                sel_data  = s_axis_tdata[i*DATA_WIDTH +: DATA_WIDTH];
                sel_keep  = s_axis_tkeep[i*KEEP_WIDTH +: KEEP_WIDTH];
            end
        end
    end

    assign slot_ready    = !m_axis_tvalid || m_axis_tready;
    assign s_axis_tready = (state == LOCKED && slot_ready) ? grant : '0;
    assign accept        = (state == LOCKED) && slot_ready && sel_valid;
    assign grant_o       = grant;
    assign busy_o        = (state == LOCKED);

    always_comb begin
        state_next = state;
        grant_next = grant;
        ptr_next   = ptr;
        case (state)
            IDLE: begin
                if (found) begin
                    state_next = LOCKED;
                    ptr_next   = winner;
                    for (int i = 0; i < CHANNEL_NUM; i++) begin
                        grant_next[i] = (SEL_WIDTH'(i) == winner);
                    end
                end
            end
            LOCKED: begin
                if (accept && sel_last) begin
                    state_next = IDLE;
                    grant_next = '0;
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
            end
        endcase
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Pointer resets to the top channel so channel 0 wins the first arbitration.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            grant <= '0;
            ptr   <= SEL_WIDTH'(CHANNEL_NUM - 1);
        end else begin
            grant <= grant_next;
            ptr   <= ptr_next;
        end
    end

    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
        end else if (accept) begin
            m_axis_tvalid <= 1'b1;
            m_axis_tdata  <= sel_data;
            m_axis_tkeep  <= sel_keep;
            m_axis_tlast  <= sel_last;
        end else if (m_axis_tready) begin
            m_axis_tvalid <= 1'b0;
        end
    end

`ifdef AXIS_RR_PACKET_ARBITER_TID_EN
    // While locked the pointer holds the granted channel index.
    always_ff @(posedge axis_clk) begin
        if (axis_rst) begin
            m_axis_tid <= '0;
        end else if (accept) begin
            m_axis_tid <= ptr;
        end
    end
`else
    // No channel-index sideband in this build.
`endif

endmodule

// File: tb/tb_axis_rr_packet_arbiter.sv
// Directed self-checking bench for axis_rr_packet_arbiter (8 channels, 32-bit data).
// Also checks m_axis_tid when built with AXIS_RR_PACKET_ARBITER_TID_EN.
module tb_axis_rr_packet_arbiter;

    localparam int DW = 32;
    localparam int CN = 8;
    localparam int KW = DW / 8;
    localparam int SW = 3;

    logic              axis_clk = 1'b0;
    logic              axis_rst = 1'b1;
    logic [CN-1:0]     s_axis_tvalid;
    logic [CN-1:0]     s_axis_tready;
    logic [CN*DW-1:0]  s_axis_tdata;
    logic [CN*KW-1:0]  s_axis_tkeep;
    logic [CN-1:0]     s_axis_tlast;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic [DW-1:0]     m_axis_tdata;
    logic [KW-1:0]     m_axis_tkeep;
    logic              m_axis_tlast;
`ifdef AXIS_RR_PACKET_ARBITER_TID_EN
    logic [SW-1:0]     m_axis_tid;
`endif
    logic [CN-1:0]     grant_o;
    logic              busy_o;

    int vectors     = 0;
    int miscompares = 0;

    int            total [CN];
    int            sent  [CN];
    int            plen  [CN];
    logic [DW-1:0] base  [CN];

    logic [DW-1:0] exp_data [$];
    logic          exp_last [$];
    int            exp_ch   [$];

    axis_rr_packet_arbiter #(.DATA_WIDTH(DW), .CHANNEL_NUM(CN)) dut (
        .axis_clk      (axis_clk),
        .axis_rst      (axis_rst),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tkeep  (s_axis_tkeep),
        .s_axis_tlast  (s_axis_tlast),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tlast  (m_axis_tlast),
`ifdef AXIS_RR_PACKET_ARBITER_TID_EN
        .m_axis_tid    (m_axis_tid),
`endif
        .grant_o       (grant_o),
        .busy_o        (busy_o)
    );

    always #5 axis_clk = ~axis_clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Sources present beat 'sent' of their stream; keep is trimmed on packet-final beats.
    task automatic driveSources();
        for (int c = 0; c < CN; c++) begin
            if (sent[c] < total[c]) begin
                logic last;
                last = ((sent[c] % plen[c]) == plen[c] - 1);
                s_axis_tvalid[c]            = 1'b1;
                s_axis_tdata[c*DW +: DW]    = base[c] + DW'(sent[c]);
                s_axis_tlast[c]             = last;
                s_axis_tkeep[c*KW +: KW]    = last ? 4'h7 : 4'hF;
            end else begin
                s_axis_tvalid[c]            = 1'b0;
                s_axis_tdata[c*DW +: DW]    = '0;
                s_axis_tlast[c]             = 1'b0;
                s_axis_tkeep[c*KW +: KW]    = '0;
            end
        end
    endtask

    task automatic pushPacket(input int ch, input int start, input int len);
        for (int b = start; b < start + len; b++) begin
            exp_data.push_back(base[ch] + DW'(b));
            exp_last.push_back(b == start + len - 1);
            exp_ch.push_back(ch);
        end
    endtask

    task automatic applyStimulus(input logic rdy);
        logic [CN-1:0] acc;
        logic          stall;
        logic [DW-1:0] held_d;
        logic          held_l;
        driveSources();
        m_axis_tready = rdy;
        #1;
        acc = s_axis_tvalid & s_axis_tready;
        checkOutput("tready_onehot", 64'($countones(s_axis_tready) <= 1), 64'(1));
        if (m_axis_tvalid && m_axis_tready) begin
            if (exp_data.size() == 0) begin
                vectors++;
                miscompares++;
                $error("[TB] FAIL extra_beat: observed data 0x%0h expected no beat", m_axis_tdata);
            end else begin
                checkOutput("out_data", 64'(m_axis_tdata), 64'(exp_data[0]));
                checkOutput("out_last", 64'(m_axis_tlast), 64'(exp_last[0]));
                checkOutput("out_keep", 64'(m_axis_tkeep), exp_last[0] ? 64'h7 : 64'hF);
`ifdef AXIS_RR_PACKET_ARBITER_TID_EN
                checkOutput("out_tid", 64'(m_axis_tid), 64'(exp_ch[0]));
`endif
                void'(exp_data.pop_front());
                void'(exp_last.pop_front());
                void'(exp_ch.pop_front());
            end
        end
        stall  = m_axis_tvalid && !m_axis_tready;
        held_d = m_axis_tdata;
        held_l = m_axis_tlast;
        if (stall) checkOutput("stall_tready", 64'(s_axis_tready), 64'(0));
        @(posedge axis_clk);
        #2;
        for (int c = 0; c < CN; c++) if (acc[c]) sent[c]++;
        if (stall) begin
            checkOutput("stall_valid", 64'(m_axis_tvalid), 64'(1));
            checkOutput("stall_data", 64'(m_axis_tdata), 64'(held_d));
            checkOutput("stall_last", 64'(m_axis_tlast), 64'(held_l));
        end
    endtask

    task automatic resetDut();
        for (int c = 0; c < CN; c++) begin
            total[c] = 0;
            sent[c]  = 0;
        end
        driveSources();
        m_axis_tready = 1'b1;
        axis_rst      = 1'b1;
        @(posedge axis_clk);
        #2;
        axis_rst = 1'b0;
        exp_data.delete();
        exp_last.delete();
        exp_ch.delete();
    endtask

    initial begin
        int n;
        for (int c = 0; c < CN; c++) begin
            plen[c] = 1;
            base[c] = '0;
        end
        resetDut();
        checkOutput("rst_grant", 64'(grant_o), 64'(0));
        checkOutput("rst_tready", 64'(s_axis_tready), 64'(0));
        checkOutput("rst_mvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("rst_mdata", 64'(m_axis_tdata), 64'(0));
        checkOutput("rst_busy", 64'(busy_o), 64'(0));

        $display("[TB] idle for 10 clocks");
        repeat (10) begin
            applyStimulus(1'b1);
            checkOutput("idle_grant", 64'(grant_o), 64'(0));
            checkOutput("idle_tready", 64'(s_axis_tready), 64'(0));
            checkOutput("idle_mvalid", 64'(m_axis_tvalid), 64'(0));
        end

        $display("[TB] channel 3 single 4-beat packet");
        base[3] = 32'hA0; plen[3] = 4; total[3] = 4; sent[3] = 0;
        pushPacket(3, 0, 4);
        applyStimulus(1'b1);
        checkOutput("c3_grant", 64'(grant_o), 64'h08);
        checkOutput("c3_busy", 64'(busy_o), 64'(1));
        checkOutput("c3_mvalid0", 64'(m_axis_tvalid), 64'(0));
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b1);
            checkOutput("c3_mvalid", 64'(m_axis_tvalid), 64'(1));
            checkOutput("c3_mdata", 64'(m_axis_tdata), 64'(32'hA0 + k));
            checkOutput("c3_mlast", 64'(m_axis_tlast), 64'(k == 3));
        end
        checkOutput("c3_grant_end", 64'(grant_o), 64'(0));
        applyStimulus(1'b1);
        checkOutput("c3_drained", 64'(m_axis_tvalid), 64'(0));
        checkOutput("c3_queue", 64'(exp_data.size()), 64'(0));

        $display("[TB] channels 0,2,7 round robin");
        resetDut();
        foreach (total[c]) if (c == 0 || c == 2 || c == 7) begin
            base[c] = 32'h1000_0000 | (DW'(c) << 8);
            plen[c] = 2; total[c] = 4; sent[c] = 0;
        end
        for (int p = 0; p < 2; p++) begin
            pushPacket(0, p*2, 2);
            pushPacket(2, p*2, 2);
            pushPacket(7, p*2, 2);
        end
        n = 0;
        while (exp_data.size() > 0 && n < 100) begin
            applyStimulus(1'b1);
            n++;
        end
        checkOutput("rr_drained", 64'(exp_data.size()), 64'(0));
        checkOutput("rr_cycles", 64'(n), 64'(19));

        $display("[TB] channel 1 with backpressure 1,0,0");
        base[1] = 32'h2000_0000; plen[1] = 5; total[1] = 5; sent[1] = 0;
        pushPacket(1, 0, 5);
        n = 0;
        while (exp_data.size() > 0 && n < 60) begin
            applyStimulus((n % 3) == 0);
            n++;
        end
        checkOutput("bp_drained", 64'(exp_data.size()), 64'(0));

        $display("[TB] reset pulse mid-packet on channel 5");
        base[5] = 32'h3000_0000; plen[5] = 6; total[5] = 6; sent[5] = 0;
        pushPacket(5, 0, 6);
        repeat (4) applyStimulus(1'b1);
        checkOutput("mid_busy", 64'(busy_o), 64'(1));
        checkOutput("mid_grant", 64'(grant_o), 64'h20);
        resetDut();
        checkOutput("rst5_mvalid", 64'(m_axis_tvalid), 64'(0));
        checkOutput("rst5_grant", 64'(grant_o), 64'(0));
        checkOutput("rst5_tready", 64'(s_axis_tready), 64'(0));
        base[0] = 32'h4000_0000; plen[0] = 1; total[0] = 1; sent[0] = 0;
        base[6] = 32'h4600_0000; plen[6] = 1; total[6] = 1; sent[6] = 0;
        pushPacket(0, 0, 1);
        pushPacket(6, 0, 1);
        applyStimulus(1'b1);
        checkOutput("rst5_first_grant", 64'(grant_o), 64'h01);
        n = 0;
        while (exp_data.size() > 0 && n < 20) begin
            applyStimulus(1'b1);
            n++;
        end
        checkOutput("rst5_drained", 64'(exp_data.size()), 64'(0));

        $display("[TB] channels 4 and 6 alternating");
        base[4] = 32'h5400_0000; plen[4] = 2; total[4] = 4; sent[4] = 0;
        base[6] = 32'h5600_0000; plen[6] = 2; total[6] = 4; sent[6] = 0;
        pushPacket(4, 0, 2);
        pushPacket(6, 0, 2);
        pushPacket(4, 2, 2);
        pushPacket(6, 2, 2);
        n = 0;
        while (exp_data.size() > 0 && n < 40) begin
            applyStimulus(1'b1);
            n++;
        end
        checkOutput("c46_drained", 64'(exp_data.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
